// File: rtl/pdn_power_sequencer_if.sv
// Control and rail bundle between the power-management controller, the rail
// switches and pdn_power_sequencer.
interface pdn_power_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 7
);
  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  logic                   pwr_req;
  logic [NUM_DOMAINS-1:0] dom_mask;
  logic                   fault_clr;
  logic [NUM_DOMAINS-1:0] vdd_good;
  logic [NUM_DOMAINS-1:0] vdd_en;
  logic                   busy;
  logic                   all_on;
  logic                   fault;
  logic [IDX_W-1:0]       fault_dom;
  logic [IDX_W-1:0]       cur_dom;

  modport master (
    output pwr_req, dom_mask, fault_clr, vdd_good,
    input  vdd_en, busy, all_on, fault, fault_dom, cur_dom
  );

  modport slave (
    input  pwr_req, dom_mask, fault_clr, vdd_good,
    output vdd_en, busy, all_on, fault, fault_dom, cur_dom
  );
endinterface

// File: rtl/pdn_power_sequencer.sv
// Ordered VDD rail sequencer with stagger, masking, timeout/brownout fault and abort.
// Optional macro PDN_SEQ_GOOD_FILTER_EN adds a synchroniser + 3-sample filter on vdd_good.
module pdn_power_sequencer #(
  parameter int unsigned NUM_DOMAINS = 7,
  parameter int unsigned STAGGER     = 16,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned IDX_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pdn_power_sequencer_if.slave bus
);

  localparam int unsigned TMR_MAX = (TIMEOUT > STAGGER) ? TIMEOUT : STAGGER;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_DOM = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(TMR_MAX);

  typedef enum logic [3:0] {
    S_OFF, S_UP_STEP, S_UP_WAIT, S_UP_GAP, S_ON,
    S_DN_STEP, S_DN_WAIT, S_DN_GAP, S_FAULT
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_DOMAINS-1:0] vdd_en_q, vdd_en_d;
  logic [IDX_W-1:0]       cur_dom_q, cur_dom_d;
  logic [IDX_W-1:0]       fault_dom_q, fault_dom_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d, tmr_inc;
  logic                   busy_q, all_on_q, fault_q;

  logic [NUM_DOMAINS-1:0] good;
  logic                   brown;
  logic [IDX_W-1:0]       brown_idx;
  logic                   cur_last, cur_first;
  state_e                 up_nxt_state, dn_nxt_state;
  logic [IDX_W-1:0]       up_nxt_dom, dn_nxt_dom;

`ifdef PDN_SEQ_GOOD_FILTER_EN
  logic [NUM_DOMAINS-1:0] sync1_q, sync2_q, hist1_q, hist2_q, filt_q;
  logic [NUM_DOMAINS-1:0] stable;

  // A bit only moves once three consecutive synchronised samples agree.
  assign stable = ~(sync2_q ^ hist1_q) & ~(hist1_q ^ hist2_q);
  assign good   = (stable & sync2_q) | (~stable & filt_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
      filt_q  <= '0;
    end else begin
      sync1_q <= bus.vdd_good;
      sync2_q <= sync1_q;
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
      filt_q  <= good;
    end
  end
`else
  assign good = bus.vdd_good;
`endif

  // Lowest enabled rail that has lost power-good.
  always_comb begin
    brown     = 1'b0;
    brown_idx = '0;
    for (int i = int'(NUM_DOMAINS) - 1; i >= 0; i--) begin
      if (vdd_en_q[i] && !good[i]) begin
        brown     = 1'b1;
        brown_idx = IDX_W'(i);
      end
    end
  end

  assign cur_last     = (cur_dom_q == LAST_DOM);
  assign cur_first    = (cur_dom_q == '0);
  assign up_nxt_state = cur_last ? S_ON : S_UP_STEP;
  assign up_nxt_dom   = cur_last ? cur_dom_q : cur_dom_q + IDX_W'(1);
  assign dn_nxt_state = cur_first ? S_OFF : S_DN_STEP;
  assign dn_nxt_dom   = cur_first ? cur_dom_q : cur_dom_q - IDX_W'(1);
  assign tmr_inc      = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + TMR_W'(1);

  always_comb begin
    state_d     = state_q;
    vdd_en_d    = vdd_en_q;
    cur_dom_d   = cur_dom_q;
    fault_dom_d = fault_dom_q;
    tmr_d       = tmr_q;
    unique case (state_q)
      S_OFF: begin
        if (bus.pwr_req) begin
          state_d   = S_UP_STEP;
          cur_dom_d = '0;
        end
      end
      S_UP_STEP: begin
        if (!bus.pwr_req) begin
          state_d = S_DN_STEP;
        end else if (!bus.dom_mask[cur_dom_q]) begin
          state_d   = up_nxt_state;
          cur_dom_d = up_nxt_dom;
        end else begin
          vdd_en_d[cur_dom_q] = 1'b1;
          tmr_d               = '0;
          state_d             = S_UP_WAIT;
        end
      end
      S_UP_WAIT: begin
        // Reversal wins over a timeout on the same edge.
        if (!bus.pwr_req) begin
          state_d = S_DN_STEP;
        end else if (good[cur_dom_q]) begin
          tmr_d = '0;
          if (STAGGER != 0) begin
            state_d = S_UP_GAP;
          end else begin
            state_d   = up_nxt_state;
            cur_dom_d = up_nxt_dom;
          end
        end else if (tmr_q == TMO_LAST) begin
          state_d     = S_FAULT;
          vdd_en_d    = '0;
          fault_dom_d = cur_dom_q;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_UP_GAP: begin
        if (!bus.pwr_req) begin
          state_d = S_DN_STEP;
        end else if (tmr_q == GAP_LAST) begin
          state_d   = up_nxt_state;
          cur_dom_d = up_nxt_dom;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_ON: begin
        if (brown) begin
          state_d     = S_FAULT;
          vdd_en_d    = '0;
          fault_dom_d = brown_idx;
        end else if (!bus.pwr_req) begin
          state_d   = S_DN_STEP;
          cur_dom_d = LAST_DOM;
        end
      end
      S_DN_STEP: begin
        if (bus.pwr_req) begin
          state_d = S_UP_STEP;
        end else if (!vdd_en_q[cur_dom_q]) begin
          state_d   = dn_nxt_state;
          cur_dom_d = dn_nxt_dom;
        end else begin
          vdd_en_d[cur_dom_q] = 1'b0;
          tmr_d               = '0;
          state_d             = S_DN_WAIT;
        end
      end
      S_DN_WAIT: begin
        if (bus.pwr_req) begin
          state_d = S_UP_STEP;
        end else if (!good[cur_dom_q]) begin
          tmr_d = '0;
          if (STAGGER != 0) begin
            state_d = S_DN_GAP;
          end else begin
            state_d   = dn_nxt_state;
            cur_dom_d = dn_nxt_dom;
          end
        end else if (tmr_q == TMO_LAST) begin
          state_d     = S_FAULT;
          vdd_en_d    = '0;
          fault_dom_d = cur_dom_q;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_DN_GAP: begin
        if (bus.pwr_req) begin
          state_d = S_UP_STEP;
        end else if (tmr_q == GAP_LAST) begin
          state_d   = dn_nxt_state;
          cur_dom_d = dn_nxt_dom;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_FAULT: begin
        if (bus.fault_clr) state_d = S_OFF;
      end
      default: begin
        state_d  = S_OFF;
        vdd_en_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_OFF;
      vdd_en_q    <= '0;
      cur_dom_q   <= '0;
      fault_dom_q <= '0;
      tmr_q       <= '0;
      busy_q      <= 1'b0;
      all_on_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      vdd_en_q    <= vdd_en_d;
      cur_dom_q   <= cur_dom_d;
      fault_dom_q <= fault_dom_d;
      tmr_q       <= tmr_d;
      busy_q      <= (state_d inside {S_UP_STEP, S_UP_WAIT, S_UP_GAP,
                                      S_DN_STEP, S_DN_WAIT, S_DN_GAP});
      all_on_q    <= (state_d == S_ON);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign bus.vdd_en    = vdd_en_q;
  assign bus.busy      = busy_q;
  assign bus.all_on    = all_on_q;
  assign bus.fault     = fault_q;
  assign bus.fault_dom = fault_dom_q;
  assign bus.cur_dom   = cur_dom_q;

endmodule

// File: doc/pdn_power_sequencer.md
Name: pdn_power_sequencer

Overview:
Parametrised supply-domain sequencer that drives the enable of NUM_DOMAINS independent VDD rails. Rails power up in ascending index order and down in descending order. Each step waits for the rail's power-good, and consecutive rails are separated by a programmable stagger to limit inrush. The block sits at top level between the power-management controller and the rail switches that feed the block instances sharing each VDD net. It adds per-domain masking, timeout/brownout fault detection and abort-and-reverse, none of which a fixed static netlist provides.

Parameters:
NUM_DOMAINS, 7, number of VDD rails controlled (1..32).
STAGGER, 16, idle cycles between a rail reaching good and the next rail's step (0 allowed).
TIMEOUT, 255, max cycles to wait for vdd_good to reach the target level before fault (>=1).
IDX_W, $clog2(NUM_DOMAINS) (min 1), width of domain index outputs.

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  reset, synchronous, active-high.
pwr_req  input  1  1 = power selected domains on, 0 = power them off.
dom_mask  input  NUM_DOMAINS  1 = domain participates; sampled per step.
fault_clr  input  1  single-cycle pulse; clears FAULT.
vdd_good  input  NUM_DOMAINS  rail power-good from each switch.
vdd_en  output  NUM_DOMAINS  rail enables.
busy  output  1  sequencing in progress (UP_*/DN_* states).
all_on  output  1  in ON state.
fault  output  1  in FAULT state.
fault_dom  output  IDX_W  index of the failing domain, held while fault=1.
cur_dom  output  IDX_W  domain currently being stepped.

Behaviour:
- Reset (rst=1 at a clock edge): state OFF. vdd_en=0, busy=0, all_on=0, fault=0, fault_dom=0, cur_dom=0, counters=0. Reset mid-sequence drops all enables in the same edge.
- States: OFF, UP_STEP, UP_WAIT, UP_GAP, ON, DN_STEP, DN_WAIT, DN_GAP, FAULT.
- OFF: pwr_req=1 -> UP_STEP with cur_dom=0. vdd_en[0] can rise no earlier than 1 cycle after pwr_req is sampled.
- UP_STEP: if dom_mask[cur_dom]=0, skip it (1 cycle, no enable, no gap) to the next index. Otherwise set vdd_en[cur_dom]=1, clear the timer, go to UP_WAIT.
- UP_WAIT: when vdd_good[cur_dom]=1, go to UP_GAP (or advance directly if STAGGER=0). If the timer reaches TIMEOUT first, go to FAULT.
- UP_GAP: count STAGGER cycles, then go to the next index in UP_STEP. After the last index, go to ON.
- ON: all_on=1. Any domain with vdd_en=1 and vdd_good=0 (brownout) -> FAULT with fault_dom = lowest such index. pwr_req=0 -> DN_STEP with cur_dom=NUM_DOMAINS-1.
- DN_STEP / DN_WAIT / DN_GAP mirror the up path in descending order:
  - Only domains with vdd_en=1 are stepped; the others are skipped in 1 cycle.
  - DN_STEP clears vdd_en[cur_dom]. DN_WAIT waits for vdd_good[cur_dom]=0, with the same timeout -> FAULT.
  - After index 0, go to OFF.
- Abort: pwr_req=0 in any UP_* state -> DN_STEP starting at the current cur_dom (already-enabled rails unwind). pwr_req=1 in any DN_* state -> UP_STEP at the current cur_dom. The reversal is taken on the next edge. In WAIT it overrides the timeout when both occur on the same edge.
- FAULT: all vdd_en cleared on the entry edge. fault=1, busy=0, fault_dom latched. Stays until a fault_clr pulse, then OFF. A pwr_req level present at exit restarts sequencing one cycle later. fault_clr outside FAULT is ignored.
- Timer width: clog2(max(TIMEOUT,STAGGER)+1). Timers saturate and never wrap.
- cur_dom wraps neither way; its range is 0..NUM_DOMAINS-1.

Optional Feature:
PDN_SEQ_GOOD_FILTER_EN: when defined, each vdd_good bit passes through a 2-flop synchroniser plus a 3-cycle stability filter. A bit changes its filtered value only after 3 consecutive equal synchronised samples, so the observed good-response latency grows by 4 cycles. The timeout counts against the filtered value. When undefined, vdd_good is used directly (it must already be synchronous to clk) and the brownout check reacts in 1 cycle.

Test Plan:
- Full up/down sequence. Setup: NUM_DOMAINS=3, STAGGER=4, TIMEOUT=10, mask=3'b111, good follows en after 2 cycles. Response: en[0] rises 1 cycle after pwr_req, en[1] 7 cycles later, en[2] 7 cycles after that, all_on after the last gap. pwr_req=0 -> en[2], en[1], en[0] clear in that order, 7 cycles apart.
- Masking: mask=3'b101. Response: en[1] never asserts, domain 1 costs exactly 1 cycle, en[2] rises 8 cycles after en[0].
- Timeout: vdd_good[1] held 0. Response: FAULT 10 cycles after en[1] rises, all en=0 on the same edge, fault_dom=1. fault_clr -> OFF, then restart while pwr_req=1.
- Brownout: drop vdd_good[2] for 1 cycle in ON. Response: fault=1 next cycle, fault_dom=2, vdd_en=0.
- Abort: pwr_req=0 during UP_GAP after domain 1. Response: en[1] then en[0] clear, state OFF, en[2] never set. Reset asserted mid-UP_WAIT -> all outputs 0 next edge.
- With PDN_SEQ_GOOD_FILTER_EN: a 2-cycle vdd_good glitch in ON causes no fault. A 3-cycle drop causes a fault.
